// File: rtl/spi_cfg_master.sv
// SPI mode-0 write-only master: each accepted request becomes one {addr, data}
// frame, MSB first, framed by spi_nss. All SPI pins come straight from flops.
module spi_cfg_master #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int NSS_GAP    = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       spi_nss
);

  localparam int CNT_MAX = (CLK_DIV > NSS_GAP) ? CLK_DIV : NSS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(NSS_GAP - 1);
  localparam logic [4:0]       LAST_BIT = 5'(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  // spi_mosi is the frame's leading bit; shreg holds the 15 bits still to send.
  logic [14:0]      shreg;

  // req_valid/req_ready: a request transfers on the clk edge where both are high;
  // req_ready is high only in IDLE, so requests presented while busy are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_nss   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            shreg     <= {req_addr[6:0], req_data};
            spi_mosi  <= req_addr[7];
            spi_nss   <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            spi_clk <= 1'b1;
            bit_cnt <= bit_cnt + 5'd1;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            spi_clk <= 1'b0;
            state   <= SHIFT_LO;
            // After the final rising edge spi_mosi keeps bit0 through HOLD.
            if (bit_cnt < LAST_BIT) begin
              spi_mosi <= shreg[14];
              shreg    <= {shreg[13:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT_LO: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state <= HOLD;
            end else begin
              spi_clk <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
              state   <= SHIFT_HI;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            spi_nss  <= 1'b1;
            spi_mosi <= 1'b0;
            done     <= 1'b1;
            state    <= GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: a default instance (CLK_DIV=4, NSS_GAP=2) and a
// fast instance (CLK_DIV=1, NSS_GAP=1), each with a frame-capturing monitor.
module tb_spi_cfg_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic       req_valid, req_ready, busy, done, spi_clk, spi_mosi, spi_nss;
  logic [7:0] req_addr, req_data;
  // fast instance
  logic       req1_valid, req1_ready, busy1, done1, spi_clk1, spi_mosi1, spi_nss1;
  logic [7:0] req1_addr, req1_data;

  spi_cfg_master dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_nss(spi_nss)
  );

  spi_cfg_master #(.CLK_DIV(1), .FRAME_BITS(16), .NSS_GAP(1)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(req1_valid), .req_ready(req1_ready),
    .req_addr(req1_addr), .req_data(req1_data), .busy(busy1), .done(done1),
    .spi_clk(spi_clk1), .spi_mosi(spi_mosi1), .spi_nss(spi_nss1)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp1_q[$];
  int          acc0_q[$];
  int          acc1_q[$];
  int          n_done0 = 0, n_done1 = 0, done0_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=timeout_or_unexpected exp=event (t=%0t)", name, $time);
  endtask

  // ---------------- SPI monitor ----------------
  typedef struct {
    logic [15:0] cap;
    int          edges;
    int          low_cnt;
    int          high_run;
    int          last_gap;
    logic        prev_clk;
    logic        prev_nss;
    logic        prev_mosi;
    logic        frame_end;
    logic        mosi_chg;
    logic [15:0] last_cap;
    int          last_edges;
    int          last_low;
  } mon_t;

  function automatic mon_t mon_init();
    mon_t m;
    m.cap = '0; m.edges = 0; m.low_cnt = 0; m.high_run = 0; m.last_gap = 0;
    m.prev_clk = 1'b0; m.prev_nss = 1'b1; m.prev_mosi = 1'b0;
    m.frame_end = 1'b0; m.mosi_chg = 1'b0;
    m.last_cap = '0; m.last_edges = 0; m.last_low = 0;
    return m;
  endfunction

  function automatic mon_t mon_next(input mon_t mi, input logic sclk, input logic mosi,
                                    input logic nss);
    mon_t m = mi;
    m.frame_end = 1'b0;
    m.mosi_chg  = (mosi != m.prev_mosi);
    if (!nss) m.low_cnt++;
    else      m.high_run++;
    if (sclk && !m.prev_clk) begin
      m.cap = {m.cap[14:0], mosi};
      m.edges++;
    end
    if (!nss && m.prev_nss) begin
      m.last_gap = m.high_run;
      m.high_run = 0;
    end
    if (nss && !m.prev_nss) begin
      m.frame_end  = 1'b1;
      m.last_cap   = m.cap;
      m.last_edges = m.edges;
      m.last_low   = m.low_cnt;
      m.cap = '0; m.edges = 0; m.low_cnt = 0;
    end
    m.prev_clk  = sclk;
    m.prev_nss  = nss;
    m.prev_mosi = mosi;
    return m;
  endfunction

  mon_t mon0, mon1;

  always @(negedge clk) begin
    #1;
    if (!rstn) begin
      mon0 = mon_init();
    end else begin
      if (req_valid && req_ready) acc0_q.push_back(cyc + 1);
      mon0 = mon_next(mon0, spi_clk, spi_mosi, spi_nss);
      if (mon0.mosi_chg) check("mosi_change_while_clk_low0", 32'(spi_clk), 0);
      if (done) begin
        n_done0++;
        done0_cyc = cyc;
      end
      if (mon0.frame_end) begin
        check("done_with_nss_rise0", 32'(done), 1);
        check("rising_edges0", mon0.last_edges, 16);
        check("nss_low_cycles0", mon0.last_low, 136);
        if (exp_q.size() == 0) fail_now("unexpected_frame0");
        else check("frame_bits0", 32'(mon0.last_cap), 32'(exp_q.pop_front()));
      end else if (done) begin
        fail_now("stray_done0");
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rstn) begin
      mon1 = mon_init();
    end else begin
      if (req1_valid && req1_ready) acc1_q.push_back(cyc + 1);
      mon1 = mon_next(mon1, spi_clk1, spi_mosi1, spi_nss1);
      if (mon1.mosi_chg) check("mosi_change_while_clk_low1", 32'(spi_clk1), 0);
      if (done1) n_done1++;
      if (mon1.frame_end) begin
        check("done_with_nss_rise1", 32'(done1), 1);
        check("rising_edges1", mon1.last_edges, 16);
        check("nss_low_cycles1", mon1.last_low, 34);
        if (exp1_q.size() == 0) fail_now("unexpected_frame1");
        else check("frame_bits1", 32'(mon1.last_cap), 32'(exp1_q.pop_front()));
      end else if (done1) begin
        fail_now("stray_done1");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acc(input int which, input int target);
    int n = 0;
    while (((which == 0) ? acc0_q.size() : acc1_q.size()) < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (((which == 0) ? acc0_q.size() : acc1_q.size()) < target) fail_now("accept_timeout");
  endtask

  task automatic wait_done(input int which, input int target);
    int n = 0;
    while (((which == 0) ? n_done0 : n_done1) < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (((which == 0) ? n_done0 : n_done1) < target) fail_now("done_timeout");
  endtask

  task automatic single_write0(input logic [7:0] a, input logic [7:0] d,
                               input logic [15:0] expf);
    int n, dn;
    n  = acc0_q.size();
    dn = n_done0;
    exp_q.push_back(expf);
    @(negedge clk);
    check("ready_in_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_addr = a; req_data = d;
    wait_acc(0, n + 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    check("ready_low_after_accept", 32'(req_ready), 0);
    check("nss_low_after_accept", 32'(spi_nss), 0);
    check("mosi_first_bit", 32'(spi_mosi), 32'(expf[15]));
    wait_done(0, dn + 1);
    check("accept_to_done", done0_cyc - acc0_q[n], 136);
    @(negedge clk);
    check("ready_still_low_in_gap", 32'(req_ready), 0);
    @(negedge clk);
    check("ready_two_after_done", 32'(req_ready), 1);
    check("busy_clear_in_idle", 32'(busy), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_frame;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n, dn, k;
    vecs[0] = '{8'h12, 8'hA5, 16'b0001_0010_1010_0101};
    vecs[1] = '{8'h00, 8'h7F, 16'b0000_0000_0111_1111};
    vecs[2] = '{8'hFF, 8'h00, 16'b1111_1111_0000_0000};
    vecs[3] = '{8'h55, 8'hAA, 16'b0101_0101_1010_1010};
    vecs[4] = '{8'h81, 8'h3C, 16'b1000_0001_0011_1100};

    rstn = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    repeat (3) @(negedge clk);
    check("rst_spi_nss", 32'(spi_nss), 1);
    check("rst_spi_clk", 32'(spi_clk), 0);
    check("rst_spi_mosi", 32'(spi_mosi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 1);
    check("ready_after_reset1", 32'(req1_ready), 1);

    for (int i = 0; i < 5; i++) single_write0(vecs[i].addr, vecs[i].data, vecs[i].exp_frame);

    // Back-to-back with req_valid held high.
    n  = acc0_q.size();
    dn = n_done0;
    exp_q.push_back(16'h01FF);
    exp_q.push_back(16'h8000);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h01; req_data = 8'hFF;
    wait_acc(0, n + 1);
    @(negedge clk);
    req_addr = 8'h80; req_data = 8'h00;
    wait_acc(0, n + 2);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_accept_spacing", acc0_q[n + 1] - acc0_q[n], 139);
    wait_done(0, dn + 2);
    check("b2b_nss_high_cycles", mon0.last_gap, 3);
    repeat (4) @(negedge clk);

    // Request while busy must be ignored.
    n  = acc0_q.size();
    dn = n_done0;
    exp_q.push_back(16'h12A5);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h12; req_data = 8'hA5;
    wait_acc(0, n + 1);
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < acc0_q[n] + 40) @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h55; req_data = 8'h55;
    @(negedge clk);
    req_valid = 1'b0;
    wait_done(0, dn + 1);
    repeat (10) @(negedge clk);
    check("busy_req_not_accepted", acc0_q.size(), n + 1);
    check("busy_req_single_done", n_done0, dn + 1);
    check("busy_req_no_pending", exp_q.size(), 0);

    // Reset mid-frame after the 7th rising edge.
    n  = acc0_q.size();
    dn = n_done0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h12; req_data = 8'hA5;
    wait_acc(0, n + 1);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (mon0.edges != 7 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (mon0.edges != 7) fail_now("wait_seventh_edge");
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_spi_nss", 32'(spi_nss), 1);
    check("midrst_spi_clk", 32'(spi_clk), 0);
    check("midrst_spi_mosi", 32'(spi_mosi), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_ready_after_release", 32'(req_ready), 1);
    check("midrst_no_done", n_done0, dn);
    single_write0(8'h3C, 8'hC3, 16'b0011_1100_1100_0011);

    // Fast instance: CLK_DIV=1, NSS_GAP=1, back-to-back.
    n  = acc1_q.size();
    dn = n_done1;
    exp1_q.push_back(16'hFF00);
    exp1_q.push_back(16'hA55A);
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 8'hFF; req1_data = 8'h00;
    wait_acc(1, n + 1);
    @(negedge clk);
    req1_addr = 8'hA5; req1_data = 8'h5A;
    wait_acc(1, n + 2);
    @(negedge clk);
    req1_valid = 1'b0;
    check("fast_accept_spacing", acc1_q[n + 1] - acc1_q[n], 36);
    wait_done(1, dn + 2);
    check("fast_nss_high_cycles", mon1.last_gap, 2);

    repeat (5) @(negedge clk);
    check("all_frames_seen0", exp_q.size(), 0);
    check("all_frames_seen1", exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_cfg_master.md
Name: spi_cfg_master

Overview:
- SPI master that serialises register-write requests into frames for the synth's SPI configuration slave (the spi_clk / spi_mosi / spi_nss receiver inside the synth core).
- Used on-chip as a test/loopback driver, and in FPGA bring-up builds to program the synth from a simple parallel request interface.
- Each frame is one address byte followed by one data byte, MSB first, SPI mode 0, write-only (no MISO).

Parameters:
- CLK_DIV, 4: spi_clk half-period in clk cycles; legal range >= 1.
- FRAME_BITS, 16: bits per frame; fixed as {req_addr, req_data}; must equal 16.
- NSS_GAP, 2: minimum clk cycles spi_nss stays high between frames; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  write request present.
- req_ready  output  1  block can accept a request (IDLE only).
- req_addr  input  8  register address, sent first.
- req_data  input  8  register data, sent second.
- busy  output  1  high from acceptance until req_ready returns.
- done  output  1  one-cycle pulse when a frame completes (spi_nss rising).
- spi_clk  output  1  serial clock; idles low.
- spi_mosi  output  1  serial data.
- spi_nss  output  1  chip select, active low.

Behaviour:
- Clocking and reset: one clock (clk); rstn is asynchronous, active low.
- Reset values, applied immediately on rstn low, including mid-frame: spi_clk=0, spi_mosi=0, spi_nss=1, req_ready=1 after reset release, busy=0, done=0, FSM=IDLE, shift register and counters cleared. A reset mid-frame truncates the frame; no done pulse is produced.
- Handshake:
  - Accept on the rising edge where req_valid && req_ready.
  - {req_addr, req_data} is latched into a 16-bit shift register at acceptance.
  - req_ready is low in every state except IDLE. Requests presented while not ready are ignored, and the latched data is not disturbed.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
- IDLE:
  - req_ready=1, spi_nss=1, spi_clk=0, spi_mosi=0.
  - On accept: go to SETUP. In the next cycle spi_nss=0, spi_mosi=bit15, busy=1.
- SETUP: hold for CLK_DIV cycles, then go to SHIFT_HI with spi_clk=1.
- SHIFT_HI:
  - spi_clk=1 for CLK_DIV cycles, then go to SHIFT_LO with spi_clk=0.
  - Bit counter increments on each rising edge of spi_clk.
- SHIFT_LO:
  - spi_clk=0 for CLK_DIV cycles.
  - On entry, if fewer than 16 rising edges have occurred, shift: spi_mosi takes the next bit.
  - After 16 rising edges, spi_mosi holds bit0 and the next state is HOLD instead of SHIFT_HI.
- HOLD:
  - spi_nss stays low for CLK_DIV cycles after the last falling edge.
  - Then spi_nss=1, spi_mosi=0, done=1 for exactly that one cycle; go to GAP.
- GAP: NSS_GAP cycles with spi_nss=1 and req_ready=0, then go to IDLE. req_ready=1 and busy=0 in the first IDLE cycle.
- Timing summary:
  - spi_nss low for exactly (2*FRAME_BITS+2)*CLK_DIV cycles (136 with defaults).
  - spi_mosi changes only while spi_clk is low, and is stable for at least CLK_DIV cycles before each rising edge.
  - Exactly 16 spi_clk rising edges per frame.
  - Acceptance-to-next-acceptance minimum = 1 + 136 + NSS_GAP cycles (139 with defaults).
- Back-to-back: if req_valid is held high, the next request is accepted in the first IDLE cycle. There is no bubble beyond GAP.
- Counters:
  - Divider counter width clog2(CLK_DIV)+1; it wraps to 0 at each phase change.
  - Bit counter is 5 bits and saturates at 16 until the next accept.
- spi_clk, spi_mosi and spi_nss are driven directly from flops (glitch-free).

Test Plan:
- Single write, defaults (CLK_DIV=4, NSS_GAP=2), addr=0x12, data=0xA5 -> bits captured on spi_clk rising edges = 0001_0010_1010_0101; exactly 16 rising edges; spi_nss low for 136 cycles; done high 1 cycle coincident with spi_nss rising; req_ready high 2 cycles later.
- Back-to-back: req_valid held high with 0x01/0xFF then 0x80/0x00 -> second accept exactly 139 cycles after the first; spi_nss high for exactly 3 cycles between frames; both frames bit-exact.
- Request while busy: pulse req_valid with 0x55/0x55 at cycle 40 of a frame carrying 0x12/0xA5 -> not accepted; in-flight frame unchanged; no second done pulse.
- Reset mid-frame: assert rstn low after the 7th rising edge -> same cycle spi_nss=1, spi_clk=0, spi_mosi=0, busy=0; no done pulse; after release, a new 0x3C/0xC3 frame is bit-exact.
- CLK_DIV=1, NSS_GAP=1 -> spi_clk period 2 clk cycles; spi_nss low for 34 cycles; frame 0xFF/0x00 correct; accept-to-accept 36 cycles.
- Loopback into the synth's SPI slave: write 0x00/0x7F via this block -> slave register 0x00 reads 0x7F; the synth's data output stays active throughout.
